tb_watchdog_timer: RTL and testbench

Cycle-accurate watchdog for the testbench top. It sits between the clock/reset generators and the end-of-sim control logic. It counts cycles since the last activity kick from the DUT-side monitors and enforces a global cycle budget. On a timeout it raises a finish request with a cause code, which the bench acknowledges before calling $finish. It replaces a blind fixed-delay watchdog with an activity-aware one.

---
 rtl/tb_wdg_pkg.sv | 31 +++
 rtl/wdg_sat_cnt.sv | 36 +++
 rtl/tb_watchdog_timer.sv | 193 +++++++++++++++++++
 tb/tb_tb_watchdog_timer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_wdg_pkg.sv
// ---------------------------------------------------------------------------
// tb_wdg_pkg
// Shared definitions for the activity-aware simulation watchdog.
//   wdg_state_e : FSM state encoding exported on o_state
//   wdg_cause_e : reason code exported on o_cause
//   DEF_CNT_W   : default width of the idle/global counters and config inputs
//   DEF_KICK_W  : default width of the saturating kick counter
// ---------------------------------------------------------------------------
package tb_wdg_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_KICK_W = 16;

    // States visible to the bench. EXPIRED waits for the bench to
    // acknowledge the finish request; HALT is terminal until reset.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        WARN    = 3'd2,
        EXPIRED = 3'd3,
        HALT    = 3'd4
    } wdg_state_e;

    // Why the watchdog fired. Stays put once set, until reset.
    typedef enum logic [1:0] {
        NONE      = 2'd0,
        IDLE_TO   = 2'd1,
        GLOBAL_TO = 2'd2
    } wdg_cause_e;

endpackage

// File: rtl/wdg_sat_cnt.sv
// ---------------------------------------------------------------------------
// wdg_sat_cnt
// Up-counter that sticks at all-ones instead of wrapping, so a very long
// simulation can never make an idle or global count look small again.
//   clk   : system clock
//   rst_n : synchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one when not already saturated
//   cnt   : current count (registered)
// ---------------------------------------------------------------------------
module wdg_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALLONES = {W{1'b1}};

    // Clear has priority so a kick arriving together with an increment
    // request always restarts the count from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != ALLONES)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/tb_watchdog_timer.sv
// ---------------------------------------------------------------------------
// tb_watchdog_timer
// Activity-aware watchdog for the testbench top. Counts cycles since the
// last monitor kick and the total cycles spent armed; on an idle timeout or
// on exhausting the global cycle budget it raises a level finish request
// with a cause code, which the bench acknowledges before ending the run.
//
// Parameters
//   CNT_W      : width of idle/global counters and config inputs
//   MAX_CYCLES : global cycle budget counted while armed, 0 = unlimited
//   KICK_W     : width of the saturating kick counter
//
// Ports
//   clk           : system clock
//   rst_n         : synchronous active-low reset
//   i_enable      : arm the watchdog; low returns an armed watchdog to IDLE
//   i_kick        : activity pulse, one kick per high cycle
//   i_cfg_timeout : idle timeout in cycles, 0 disables it
//   i_cfg_warn    : warning threshold in idle cycles, 0 or >= timeout disables
//   i_finish_ack  : bench acknowledges the finish request
//   o_state       : current FSM state
//   o_warn        : high while in WARN
//   o_expired     : high in EXPIRED and HALT
//   o_cause       : reason for expiry, held until reset
//   o_finish_req  : high in EXPIRED until acknowledged
//   o_idle_cnt    : consecutive non-kick cycles while armed
//   o_cycle_cnt   : cycles spent armed (RUN/WARN)
//   o_kick_cnt    : total kicks, saturating
// ---------------------------------------------------------------------------
module tb_watchdog_timer
    import tb_wdg_pkg::*;
#(
    parameter int               CNT_W      = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'd1_000_000,
    parameter int               KICK_W     = DEF_KICK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_kick,
    input  logic [CNT_W-1:0]  i_cfg_timeout,
    input  logic [CNT_W-1:0]  i_cfg_warn,
    input  logic              i_finish_ack,
    output logic [2:0]        o_state,
    output logic              o_warn,
    output logic              o_expired,
    output logic [1:0]        o_cause,
    output logic              o_finish_req,
    output logic [CNT_W-1:0]  o_idle_cnt,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [KICK_W-1:0] o_kick_cnt
);

    localparam logic [CNT_W:0] ONE_EXT = {{CNT_W{1'b0}}, 1'b1};

    wdg_state_e       state;
    wdg_cause_e       cause_q;
    logic [CNT_W-1:0] cfg_timeout_q;
    logic [CNT_W-1:0] cfg_warn_q;

    logic             armed;
    logic             active;
    logic             idle_clr;
    logic             idle_inc;
    logic             cycle_inc;
    logic             kick_inc;

    logic [CNT_W:0]   idle_plus;
    logic [CNT_W:0]   cycle_plus;
    logic             warn_en;
    logic             global_hit;
    logic             idle_hit;
    logic             warn_hit;

    // Counter control. Counting only happens while armed and enabled; the
    // cycle that drops i_enable leaves the global and kick counts untouched
    // and only clears the idle count. IDLE pins the idle count at zero.
    always_comb begin
        armed     = (state == RUN) || (state == WARN);
        active    = armed && i_enable;
        idle_clr  = (state == IDLE) || (armed && (!i_enable || i_kick));
        idle_inc  = active && !i_kick;
        cycle_inc = active;
        kick_inc  = active && i_kick;
    end

    wdg_sat_cnt #(.W(CNT_W)) u_idle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idle_clr),
        .inc   (idle_inc),
        .cnt   (o_idle_cnt)
    );

    wdg_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (cycle_inc),
        .cnt   (o_cycle_cnt)
    );

    wdg_sat_cnt #(.W(KICK_W)) u_kick_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (kick_inc),
        .cnt   (o_kick_cnt)
    );

    // Threshold compares look one count ahead so the state change lands on
    // the same edge where the counter reaches the threshold. The extra top
    // bit keeps a saturated counter from wrapping into a false match.
    // A kick suppresses the idle-based hits but never the global one.
    always_comb begin
        idle_plus  = {1'b0, o_idle_cnt} + ONE_EXT;
        cycle_plus = {1'b0, o_cycle_cnt} + ONE_EXT;
        warn_en    = (cfg_warn_q != '0) && (cfg_warn_q < cfg_timeout_q);
        global_hit = (MAX_CYCLES != '0) && (cycle_plus == {1'b0, MAX_CYCLES});
        idle_hit   = !i_kick && (cfg_timeout_q != '0)
                     && (idle_plus == {1'b0, cfg_timeout_q});
        warn_hit   = !i_kick && warn_en && (idle_plus == {1'b0, cfg_warn_q});
    end

    // Main FSM with registered outputs. Priority while armed: disable,
    // global budget, idle timeout, kick (back to RUN), warning. Config is
    // captured only on the IDLE->RUN edge so later changes cannot shift a
    // running timeout. EXPIRED ignores kick/enable and waits for the ack;
    // HALT is left only through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cause_q       <= NONE;
            cfg_timeout_q <= '0;
            cfg_warn_q    <= '0;
            o_warn        <= 1'b0;
            o_expired     <= 1'b0;
            o_finish_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        state         <= RUN;
                        cfg_timeout_q <= i_cfg_timeout;
                        cfg_warn_q    <= i_cfg_warn;
                    end
                end
                RUN, WARN: begin
                    if (!i_enable) begin
                        state  <= IDLE;
                        o_warn <= 1'b0;
                    end else if (global_hit) begin
                        state        <= EXPIRED;
                        cause_q      <= GLOBAL_TO;
                        o_warn       <= 1'b0;
                        o_expired    <= 1'b1;
                        o_finish_req <= 1'b1;
                    end else if (idle_hit) begin
                        state        <= EXPIRED;
                        cause_q      <= IDLE_TO;
                        o_warn       <= 1'b0;
                        o_expired    <= 1'b1;
                        o_finish_req <= 1'b1;
                    end else if (i_kick) begin
                        state  <= RUN;
                        o_warn <= 1'b0;
                    end else if (warn_hit) begin
                        state  <= WARN;
                        o_warn <= 1'b1;
                    end
                end
                EXPIRED: begin
                    if (i_finish_ack) begin
                        state        <= HALT;
                        o_finish_req <= 1'b0;
                    end
                end
                HALT: begin
                end
                default: begin
                    state        <= IDLE;
                    o_warn       <= 1'b0;
                    o_expired    <= 1'b0;
                    o_finish_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;
    assign o_cause = cause_q;

endmodule

// File: tb/tb_tb_watchdog_timer.sv
// ---------------------------------------------------------------------------
// tb_tb_watchdog_timer
// Bench for tb_watchdog_timer. Two instances share one stimulus stream: one
// with the default global budget and one with a 50-cycle budget. A
// behavioural model per instance predicts every output each cycle; a few
// hand-computed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_tb_watchdog_timer;

    localparam int CW = 32;
    localparam int KW = 16;

    localparam int P_IDLE = 0;
    localparam int P_ACT  = 1;
    localparam int P_EXP  = 3;
    localparam int P_HALT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          kick = 1'b0;
    logic          ack = 1'b0;
    logic [CW-1:0] cfg_timeout = '0;
    logic [CW-1:0] cfg_warn = '0;

    logic [2:0]    st0, st1;
    logic          warn0, warn1, exp0, exp1, fin0, fin1;
    logic [1:0]    cause0, cause1;
    logic [CW-1:0] idle0, idle1, cyc0, cyc1;
    logic [KW-1:0] kick0, kick1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one entry per instance.
    int     m_phase [2];
    int     m_cause [2];
    longint m_idle  [2];
    longint m_cyc   [2];
    longint m_kicks [2];
    longint m_tmo   [2];
    longint m_wrn   [2];
    bit     m_valid = 1'b0;

    always #5 clk = ~clk;

    tb_watchdog_timer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_kick        (kick),
        .i_cfg_timeout (cfg_timeout),
        .i_cfg_warn    (cfg_warn),
        .i_finish_ack  (ack),
        .o_state       (st0),
        .o_warn        (warn0),
        .o_expired     (exp0),
        .o_cause       (cause0),
        .o_finish_req  (fin0),
        .o_idle_cnt    (idle0),
        .o_cycle_cnt   (cyc0),
        .o_kick_cnt    (kick0)
    );

    tb_watchdog_timer #(.MAX_CYCLES(32'd50)) dut_g (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_kick        (kick),
        .i_cfg_timeout (cfg_timeout),
        .i_cfg_warn    (cfg_warn),
        .i_finish_ack  (ack),
        .o_state       (st1),
        .o_warn        (warn1),
        .o_expired     (exp1),
        .o_cause       (cause1),
        .o_finish_req  (fin1),
        .o_idle_cnt    (idle1),
        .o_cycle_cnt   (cyc1),
        .o_kick_cnt    (kick1)
    );

    function automatic longint satAdd(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Advance the model one clock. Counters are updated first, then the
    // expiry rules are applied to the new counts: reaching the budget or
    // reaching the timeout with no kick.
    task automatic modelStep(input int k);
        longint lim;
        lim = (k == 0) ? 64'd1000000 : 64'd50;
        if (!rst_n) begin
            m_phase[k] = P_IDLE;
            m_cause[k] = 0;
            m_idle[k]  = 0;
            m_cyc[k]   = 0;
            m_kicks[k] = 0;
            m_tmo[k]   = 0;
            m_wrn[k]   = 0;
        end else begin
            case (m_phase[k])
                P_IDLE: begin
                    if (enable) begin
                        m_phase[k] = P_ACT;
                        m_tmo[k]   = longint'(cfg_timeout);
                        m_wrn[k]   = longint'(cfg_warn);
                    end
                end
                P_ACT: begin
                    if (!enable) begin
                        m_phase[k] = P_IDLE;
                        m_idle[k]  = 0;
                    end else begin
                        m_cyc[k] = satAdd(m_cyc[k], 64'hFFFF_FFFF);
                        if (kick) begin
                            m_idle[k]  = 0;
                            m_kicks[k] = satAdd(m_kicks[k], 64'hFFFF);
                        end else begin
                            m_idle[k] = satAdd(m_idle[k], 64'hFFFF_FFFF);
                        end
                        if (lim != 0 && m_cyc[k] == lim) begin
                            m_phase[k] = P_EXP;
                            m_cause[k] = 2;
                        end else if (m_tmo[k] != 0 && m_idle[k] == m_tmo[k]) begin
                            m_phase[k] = P_EXP;
                            m_cause[k] = 1;
                        end
                    end
                end
                P_EXP: begin
                    if (ack) m_phase[k] = P_HALT;
                end
                default: begin
                end
            endcase
        end
    endtask

    // Warning is simply "armed and idle for at least the warn threshold",
    // with the threshold only meaningful below a nonzero timeout.
    function automatic bit expWarn(input int k);
        return (m_phase[k] == P_ACT) && (m_wrn[k] != 0) && (m_wrn[k] < m_tmo[k])
               && (m_idle[k] >= m_wrn[k]);
    endfunction

    function automatic int expState(input int k);
        if (m_phase[k] == P_ACT) return expWarn(k) ? 2 : 1;
        return m_phase[k];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_valid <= 1'b1;
        for (int k = 0; k < 2; k++) modelStep(k);
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic compareInst(input int k, input logic [2:0] st, input logic w, input logic ex,
                               input logic [1:0] ca, input logic fi, input logic [CW-1:0] id,
                               input logic [CW-1:0] cy, input logic [KW-1:0] kc);
        checkOutput($sformatf("inst%0d_state", k), longint'(st), expState(k));
        checkOutput($sformatf("inst%0d_warn", k), longint'(w), longint'(expWarn(k)));
        checkOutput($sformatf("inst%0d_expired", k), longint'(ex),
                    (m_phase[k] == P_EXP || m_phase[k] == P_HALT) ? 1 : 0);
        checkOutput($sformatf("inst%0d_cause", k), longint'(ca), m_cause[k]);
        checkOutput($sformatf("inst%0d_finish_req", k), longint'(fi), (m_phase[k] == P_EXP) ? 1 : 0);
        checkOutput($sformatf("inst%0d_idle_cnt", k), longint'(id), m_idle[k]);
        checkOutput($sformatf("inst%0d_cycle_cnt", k), longint'(cy), m_cyc[k]);
        checkOutput($sformatf("inst%0d_kick_cnt", k), longint'(kc), m_kicks[k]);
    endtask

    // Every negedge after the first reset edge, both instances are held
    // against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            compareInst(0, st0, warn0, exp0, cause0, fin0, idle0, cyc0, kick0);
            compareInst(1, st1, warn1, exp1, cause1, fin1, idle1, cyc1, kick1);
        end
    end

    // Inputs change on the falling edge so they are stable at the next
    // rising edge. On return, outputs reflect all earlier calls.
    task automatic applyStimulus(input logic rn, input logic en, input logic kk, input logic ak);
        @(negedge clk);
        rst_n  = rn;
        enable = en;
        kick   = kk;
        ack    = ak;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", longint'(st0), 0);
        checkOutput("reset_cause", longint'(cause0), 0);
        checkOutput("reset_cycle", longint'(cyc0), 0);

        // Idle timeout of 8, no kicks
        cfg_timeout = 32'd8;
        cfg_warn    = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (c == 1) checkOutput("t1_run", longint'(st0), 1);
            if (c == 8) begin
                checkOutput("t1_not_yet", longint'(exp0), 0);
                checkOutput("t1_idle7", longint'(idle0), 7);
            end
            if (c == 9) begin
                checkOutput("t1_expired", longint'(exp0), 1);
                checkOutput("t1_finish", longint'(fin0), 1);
                checkOutput("t1_cause", longint'(cause0), 1);
            end
        end

        // Hold off the ack while kick/enable wiggle, then acknowledge
        for (int c = 1; c <= 10; c++) applyStimulus(1'b1, c[0], (c % 3) == 0, 1'b0);
        checkOutput("t5_finish_held", longint'(fin0), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_halt", longint'(st0), 4);
        checkOutput("t5_finish_low", longint'(fin0), 0);
        checkOutput("t5_expired", longint'(exp0), 1);
        checkOutput("t5_cause", longint'(cause0), 1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset out of HALT
        doReset();
        checkOutput("t6_halt_reset_state", longint'(st0), 0);
        checkOutput("t6_halt_reset_exp", longint'(exp0), 0);

        // Regular kicks keep it quiet, then silence triggers warn and expiry
        cfg_timeout = 32'd20;
        cfg_warn    = 32'd5;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, (i % 4) == 3, (i % 7) == 0);
        for (int j = 100; j <= 120; j++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (j == 101) checkOutput("t2_kicks", longint'(kick0), 25);
            if (j == 104) checkOutput("t2_warn_low", longint'(warn0), 0);
            if (j == 105) checkOutput("t2_warn_high", longint'(warn0), 1);
            if (j == 119) checkOutput("t2_not_expired", longint'(exp0), 0);
            if (j == 120) checkOutput("t2_expired", longint'(exp0), 1);
        end

        // Global budget of 50 on the second instance, kick on the limit cycle
        doReset();
        cfg_timeout = 32'd10;
        cfg_warn    = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 3) == 1, 1'b0);
            if (i == 49) checkOutput("t3_not_yet", longint'(exp1), 0);
            if (i == 50) begin
                checkOutput("t3_state", longint'(st1), 3);
                checkOutput("t3_cause", longint'(cause1), 2);
                checkOutput("t3_cycle", longint'(cyc1), 50);
                checkOutput("t3_kicks", longint'(kick1), 17);
            end
        end

        // Drop enable mid-run on the first instance
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_disable_state", longint'(st0), 0);
        checkOutput("t6_disable_cycle", longint'(cyc0), 60);
        checkOutput("t6_disable_idle", longint'(idle0), 0);

        // Kick exactly on the 6th idle cycle, then a repeat without it
        doReset();
        cfg_timeout = 32'd6;
        cfg_warn    = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b1, i == 5, 1'b0);
            if (i == 5) checkOutput("t4_idle5", longint'(idle0), 5);
            if (i == 6) begin
                checkOutput("t4_idle_cleared", longint'(idle0), 0);
                checkOutput("t4_no_expiry", longint'(exp0), 0);
            end
            if (i == 11) checkOutput("t4_not_yet", longint'(exp0), 0);
            if (i == 12) checkOutput("t4_expired", longint'(exp0), 1);
        end

        // Reset while in WARN
        doReset();
        cfg_timeout = 32'd20;
        cfg_warn    = 32'd5;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 5) checkOutput("t6_in_warn", longint'(st0), 2);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_warn_reset_state", longint'(st0), 0);
        checkOutput("t6_warn_reset_warn", longint'(warn0), 0);
        checkOutput("t6_warn_reset_cycle", longint'(cyc0), 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
